mc_ctrl_fsm: RTL and testbench
==============================

MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 0: extra wait cycles in each memory state before `mem_ready` is sampled.
REQ-002 SHALL have parameter ST_W, default 4: width of `state` output; legal values are ≥4.
REQ-003 SHALL have port `clk` in 1: the single clock; every register updates on its rising edge.
REQ-004 SHALL have port `rst` in 1: synchronous, active-high reset.
REQ-005 SHALL have port `opcode` in 6: instruction[31:26] from IR.
REQ-006 SHALL have port `func` in 6: instruction[5:0] from IR.
REQ-007 SHALL have port `mem_ready` in 1: memory completion strobe.
REQ-008 SHALL have the following 1-bit outputs: `lorD`, `IRWr`, `PCWr`, `PCWrcond`, `BrNE` (1 = branch on not-equal), `RegWr`, `ALUSrcA`, `MemWr`, `MemRd`.
REQ-009 SHALL have the following 2-bit outputs:
- `RegDst`: 00 rt, 01 rd, 10 r31.
- `MemtoReg`: 00 ALU, 01 MDR, 10 PC.
- `ALUSrcB`: 00 B, 01 const 4, 10 sext imm, 11 sext imm<<2.
- `PCsrc`: 00 ALU, 01 ALUOut, 10 jump target, 11 reg A.
REQ-010 SHALL have output `ALUOp` out 3: 000 add, 001 sub, 010 R-type by func, 011 and, 100 or, 101 slt.
REQ-011 SHALL have output `state` out ST_W: the current state, for debug.
REQ-012 SHALL have output `illegal_op` out 1: one-cycle pulse on an unknown opcode.

Function
REQ-013 SHALL hold the state register and the wait counter internally; all outputs SHALL be decoded combinationally from the state (Moore), except where memory gating is stated.
REQ-014 SHALL encode the states as: IF=0, ID=1, MADR=2, MRD=3, MWB=4, MWR=5, REX=6, RWB=7, BR=8, J=9, IEX=10, IWB=11, JAL=12, JR=13.
REQ-015 SHALL, in IF: assert `MemRd`; drive `ALUSrcB`=01 and `ALUOp`=000. `IRWr`, `PCWr` and the transition to ID SHALL occur only in the completing cycle.
REQ-016 SHALL define the completing cycle of a memory state (IF, MRD, MWR) as wait count == MEM_WAIT and `mem_ready`=1; the FSM SHALL stay in the state otherwise.
REQ-017 SHALL increment the wait counter by one per cycle in a memory state, saturate it at MEM_WAIT, and clear it on every state change.
REQ-018 SHALL, in ID: drive `ALUSrcB`=11 and `ALUOp`=000, then branch on opcode:
- 000000 → REX, except func=001000 → JR.
- lw(100011), sw(101011) → MADR.
- beq(000100), bne(000101) → BR.
- j(000010) → J.
- jal(000011) → JAL.
- addi(001000), andi(001100), ori(001101), slti(001010) → IEX.
- any other opcode → IF, with `illegal_op`=1 for that one cycle.
REQ-019 SHALL, in MADR: drive `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=000; go to MRD on lw and to MWR on sw.
REQ-020 SHALL, in MRD: assert `lorD`=1 and `MemRd`=1; on completion go to MWB.
REQ-021 SHALL, in MWB: assert `RegWr`=1 with `RegDst`=00 and `MemtoReg`=01; go to IF.
REQ-022 SHALL, in MWR: assert `lorD`=1; assert `MemWr`=1 only in the completing cycle; on completion go to IF.
REQ-023 SHALL, in REX: drive `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=010; go to RWB.
REQ-024 SHALL, in RWB: assert `RegWr`=1 with `RegDst`=01 and `MemtoReg`=00; go to IF.
REQ-025 SHALL, in IEX: drive `ALUSrcA`=1 and `ALUSrcB`=10, with `ALUOp` = 000 for addi, 011 for andi, 100 for ori, 101 for slti; go to IWB.
REQ-026 SHALL, in IWB: assert `RegWr`=1 with `RegDst`=00 and `MemtoReg`=00; go to IF.
REQ-027 SHALL, in BR: drive `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=001, `PCsrc`=01 and `PCWrcond`=1, with `BrNE`=1 iff opcode=bne; go to IF.
REQ-028 SHALL, in J: drive `PCsrc`=10 and `PCWr`=1; go to IF.
REQ-029 SHALL, in JAL: drive `PCsrc`=10, `PCWr`=1, `RegWr`=1, `RegDst`=10 and `MemtoReg`=10 in the same cycle; go to IF.
REQ-030 SHALL, in JR: drive `PCsrc`=11 and `PCWr`=1; go to IF.
REQ-031 SHALL treat any unencoded state as IF on the next cycle, with all write enables 0 while in it.
REQ-032 SHALL ignore `mem_ready` outside memory states.
REQ-033 SHALL treat `mem_ready`=1 before the counter reaches MEM_WAIT as not completing.
REQ-034 SHALL drive these defaults in every state not overriding them: all enables 0, `ALUOp`=000, `ALUSrcB`=01, all other selects 0.

Reset
REQ-035 SHALL, on `rst`=1 at a clock edge, load state=IF and wait count=0, overriding any in-progress memory wait.
REQ-036 SHALL, while `rst`=1, force `IRWr`, `PCWr`, `PCWrcond`, `RegWr`, `MemWr`, `MemRd` and `illegal_op` to 0 combinationally.
REQ-037 SHALL, on the first cycle after `rst` falls, be in IF with `MemRd`=1.

Verification
REQ-038 SHALL verify MEM_WAIT=0 with `mem_ready` tied to 1: lw → state sequence 0,1,2,3,4,0 (5 cycles); `RegWr`=1 only in state 4.
REQ-039 SHALL verify MEM_WAIT=2: sw with `mem_ready` low until the 5th MWR cycle → `MemWr`=1 exactly one cycle, in MWR cycle 5; next state IF.
REQ-040 SHALL verify bne → state 8 with `PCWrcond`=1, `BrNE`=1, `ALUOp`=001; beq → same with `BrNE`=0.
REQ-041 SHALL verify jal → state 12 with `PCWr`=1, `RegWr`=1, `RegDst`=10, `MemtoReg`=10; R-type func=001000 → state 13 with `PCsrc`=11.
REQ-042 SHALL verify opcode 111111 → `illegal_op`=1 for 1 cycle in ID, next state IF, no write enables asserted.
REQ-043 SHALL verify `rst` asserted mid-wait in MRD → state=0 on the next cycle with all enables 0; after release, IF with `MemRd`=1.

Source files
------------

// File: rtl/mc_ctrl_fsm_if.sv
// Control bus between the multicycle controller and its datapath.
// master = controller side, slave = datapath side.
interface mc_ctrl_fsm_if #(
    parameter int ST_W = 4
);
    logic [5:0]      opcode;
    logic [5:0]      func;
    logic            mem_ready;

    logic            lorD;
    logic            IRWr;
    logic            PCWr;
    logic            PCWrcond;
    logic            BrNE;
    logic            RegWr;
    logic            ALUSrcA;
    logic            MemWr;
    logic            MemRd;
    logic [1:0]      RegDst;
    logic [1:0]      MemtoReg;
    logic [1:0]      ALUSrcB;
    logic [1:0]      PCsrc;
    logic [2:0]      ALUOp;
    logic [ST_W-1:0] state;
    logic            illegal_op;

    modport master (
        input  opcode, func, mem_ready,
        output lorD, IRWr, PCWr, PCWrcond, BrNE, RegWr, ALUSrcA, MemWr, MemRd,
        output RegDst, MemtoReg, ALUSrcB, PCsrc, ALUOp, state, illegal_op
    );

    modport slave (
        output opcode, func, mem_ready,
        input  lorD, IRWr, PCWr, PCWrcond, BrNE, RegWr, ALUSrcA, MemWr, MemRd,
        input  RegDst, MemtoReg, ALUSrcB, PCsrc, ALUOp, state, illegal_op
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS-subset control FSM (Moore), with a per-state wait counter
// that stretches the memory states until the memory reports completion.
module mc_ctrl_fsm #(
    parameter int MEM_WAIT = 0,
    parameter int ST_W     = 4
) (
    input  logic          clk,
    input  logic          rst,
    mc_ctrl_fsm_if.master bus
);

    localparam int CW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
    localparam logic [CW-1:0] WAIT_MAX = CW'(MEM_WAIT);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef enum logic [3:0] {
        S_IF   = 4'd0,
        S_ID   = 4'd1,
        S_MADR = 4'd2,
        S_MRD  = 4'd3,
        S_MWB  = 4'd4,
        S_MWR  = 4'd5,
        S_REX  = 4'd6,
        S_RWB  = 4'd7,
        S_BR   = 4'd8,
        S_J    = 4'd9,
        S_IEX  = 4'd10,
        S_IWB  = 4'd11,
        S_JAL  = 4'd12,
        S_JR   = 4'd13
    } state_e;

    state_e        state_q;
    state_e        state_n;
    logic [CW-1:0] wait_q;
    logic          mem_state;
    logic          mem_done;

    assign mem_state = (state_q == S_IF) || (state_q == S_MRD) || (state_q == S_MWR);
    assign mem_done  = (wait_q == WAIT_MAX) && bus.mem_ready;
    assign bus.state = ST_W'(state_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IF;
            wait_q  <= '0;
        end else begin
            state_q <= state_n;
            if (state_n != state_q) begin
                wait_q <= '0;
            end else if (mem_state && (wait_q != WAIT_MAX)) begin
                wait_q <= wait_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_n        = state_q;
        bus.lorD       = 1'b0;
        bus.IRWr       = 1'b0;
        bus.PCWr       = 1'b0;
        bus.PCWrcond   = 1'b0;
        bus.BrNE       = 1'b0;
        bus.RegWr      = 1'b0;
        bus.ALUSrcA    = 1'b0;
        bus.MemWr      = 1'b0;
        bus.MemRd      = 1'b0;
        bus.RegDst     = 2'b00;
        bus.MemtoReg   = 2'b00;
        bus.ALUSrcB    = 2'b01;
        bus.PCsrc      = 2'b00;
        bus.ALUOp      = 3'b000;
        bus.illegal_op = 1'b0;

        case (state_q)
            S_IF: begin
                bus.MemRd = 1'b1;
                if (mem_done) begin
                    bus.IRWr = 1'b1;
                    bus.PCWr = 1'b1;
                    state_n  = S_ID;
                end
            end
            S_ID: begin
                bus.ALUSrcB = 2'b11;
                case (bus.opcode)
                    OP_RTYPE: state_n = (bus.func == FN_JR) ? S_JR : S_REX;
                    OP_LW, OP_SW: state_n = S_MADR;
                    OP_BEQ, OP_BNE: state_n = S_BR;
                    OP_J:   state_n = S_J;
                    OP_JAL: state_n = S_JAL;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_n = S_IEX;
                    default: begin
                        bus.illegal_op = 1'b1;
                        state_n        = S_IF;
                    end
                endcase
            end
            S_MADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                state_n     = (bus.opcode == OP_SW) ? S_MWR : S_MRD;
            end
            S_MRD: begin
                bus.lorD  = 1'b1;
                bus.MemRd = 1'b1;
                if (mem_done) begin
                    state_n = S_MWB;
                end
            end
            S_MWB: begin
                bus.RegWr    = 1'b1;
                bus.MemtoReg = 2'b01;
                state_n      = S_IF;
            end
            S_MWR: begin
                // The write strobe itself is gated so memory sees exactly one pulse.
                bus.lorD = 1'b1;
                if (mem_done) begin
                    bus.MemWr = 1'b1;
                    state_n   = S_IF;
                end
            end
            S_REX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b00;
                bus.ALUOp   = 3'b010;
                state_n     = S_RWB;
            end
            S_RWB: begin
                bus.RegWr  = 1'b1;
                bus.RegDst = 2'b01;
                state_n    = S_IF;
            end
            S_BR: begin
                bus.ALUSrcA  = 1'b1;
                bus.ALUSrcB  = 2'b00;
                bus.ALUOp    = 3'b001;
                bus.PCsrc    = 2'b01;
                bus.PCWrcond = 1'b1;
                bus.BrNE     = (bus.opcode == OP_BNE);
                state_n      = S_IF;
            end
            S_J: begin
                bus.PCsrc = 2'b10;
                bus.PCWr  = 1'b1;
                state_n   = S_IF;
            end
            S_IEX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                case (bus.opcode)
                    OP_ANDI: bus.ALUOp = 3'b011;
                    OP_ORI:  bus.ALUOp = 3'b100;
                    OP_SLTI: bus.ALUOp = 3'b101;
                    default: bus.ALUOp = 3'b000;
                endcase
                state_n = S_IWB;
            end
            S_IWB: begin
                bus.RegWr = 1'b1;
                state_n   = S_IF;
            end
            S_JAL: begin
                bus.PCsrc    = 2'b10;
                bus.PCWr     = 1'b1;
                bus.RegWr    = 1'b1;
                bus.RegDst   = 2'b10;
                bus.MemtoReg = 2'b10;
                state_n      = S_IF;
            end
            S_JR: begin
                bus.PCsrc = 2'b11;
                bus.PCWr  = 1'b1;
                state_n   = S_IF;
            end
            default: state_n = S_IF;
        endcase

        // Reset masks every side effect combinationally, even before the state register reloads.
        if (rst) begin
            bus.IRWr       = 1'b0;
            bus.PCWr       = 1'b0;
            bus.PCWrcond   = 1'b0;
            bus.RegWr      = 1'b0;
            bus.MemWr      = 1'b0;
            bus.MemRd      = 1'b0;
            bus.illegal_op = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: zero-wait instance driven from an instruction table via a
// scoreboard, plus a two-wait instance for the memory-stall and reset corner cases.
module tb_mc_ctrl_fsm;

    typedef struct packed {
        logic       lorD, IRWr, PCWr, PCWrcond, BrNE, RegWr, ALUSrcA, MemWr, MemRd;
        logic [1:0] RegDst, MemtoReg, ALUSrcB, PCsrc;
        logic [2:0] ALUOp;
        logic       illegal_op;
    } ctl_t;

    typedef struct {
        logic [5:0]      op;
        logic [5:0]      fn;
        int unsigned     n;
        logic [4:0][3:0] path;
    } vec_t;

    typedef struct packed {
        logic [7:0] vid;
        logic [3:0] cyc;
        logic [3:0] st;
        ctl_t       c;
    } sb_t;

    logic clk = 1'b0;
    logic rst0;
    logic rst1;
    int   n_tests;
    int   n_fail;
    sb_t  sb_q[$];
    vec_t vt[14];

    always #5 clk = ~clk;

    mc_ctrl_fsm_if #(.ST_W(4)) bus0 ();
    mc_ctrl_fsm_if #(.ST_W(4)) bus1 ();

    assign bus0.mem_ready = 1'b1;

    mc_ctrl_fsm #(.MEM_WAIT(0), .ST_W(4)) dut0 (.clk(clk), .rst(rst0), .bus(bus0));
    mc_ctrl_fsm #(.MEM_WAIT(2), .ST_W(4)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));

    function automatic ctl_t pack0();
        return {bus0.lorD, bus0.IRWr, bus0.PCWr, bus0.PCWrcond, bus0.BrNE, bus0.RegWr,
                bus0.ALUSrcA, bus0.MemWr, bus0.MemRd, bus0.RegDst, bus0.MemtoReg,
                bus0.ALUSrcB, bus0.PCsrc, bus0.ALUOp, bus0.illegal_op};
    endfunction

    function automatic ctl_t pack1();
        return {bus1.lorD, bus1.IRWr, bus1.PCWr, bus1.PCWrcond, bus1.BrNE, bus1.RegWr,
                bus1.ALUSrcA, bus1.MemWr, bus1.MemRd, bus1.RegDst, bus1.MemtoReg,
                bus1.ALUSrcB, bus1.PCsrc, bus1.ALUOp, bus1.illegal_op};
    endfunction

    // Expected outputs per state with memory always ready and no wait cycles.
    function automatic ctl_t ref_ctl(input logic [3:0] st, input logic [5:0] op);
        ctl_t c;
        c = '0;
        c.ALUSrcB = 2'b01;
        case (st)
            4'd0:  begin c.MemRd = 1; c.IRWr = 1; c.PCWr = 1; end
            4'd1:  begin
                c.ALUSrcB = 2'b11;
                c.illegal_op = !(op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                            6'b000101, 6'b000010, 6'b000011, 6'b001000,
                                            6'b001100, 6'b001101, 6'b001010});
            end
            4'd2:  begin c.ALUSrcA = 1; c.ALUSrcB = 2'b10; end
            4'd3:  begin c.lorD = 1; c.MemRd = 1; end
            4'd4:  begin c.RegWr = 1; c.MemtoReg = 2'b01; end
            4'd5:  begin c.lorD = 1; c.MemWr = 1; end
            4'd6:  begin c.ALUSrcA = 1; c.ALUSrcB = 2'b00; c.ALUOp = 3'b010; end
            4'd7:  begin c.RegWr = 1; c.RegDst = 2'b01; end
            4'd8:  begin
                c.ALUSrcA = 1; c.ALUSrcB = 2'b00; c.ALUOp = 3'b001;
                c.PCsrc = 2'b01; c.PCWrcond = 1; c.BrNE = (op == 6'b000101);
            end
            4'd9:  begin c.PCsrc = 2'b10; c.PCWr = 1; end
            4'd10: begin
                c.ALUSrcA = 1; c.ALUSrcB = 2'b10;
                c.ALUOp = (op == 6'b001100) ? 3'b011 :
                          (op == 6'b001101) ? 3'b100 :
                          (op == 6'b001010) ? 3'b101 : 3'b000;
            end
            4'd11: c.RegWr = 1;
            4'd12: begin
                c.PCsrc = 2'b10; c.PCWr = 1; c.RegWr = 1;
                c.RegDst = 2'b10; c.MemtoReg = 2'b10;
            end
            4'd13: begin c.PCsrc = 2'b11; c.PCWr = 1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_state1(input logic [3:0] t, input string name);
        bit ok = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (bus1.state == t) ok = 1;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: timeout, state %0d expected %0d", name, bus1.state, t);
        end
    endtask

    initial begin
        sb_t  e;
        ctl_t exp_rst;
        n_tests = 0;
        n_fail  = 0;
        rst0 = 1'b1;
        rst1 = 1'b1;
        bus0.opcode = '0;
        bus0.func   = '0;
        bus1.opcode = '0;
        bus1.func   = '0;
        bus1.mem_ready = 1'b1;
        exp_rst = '0;
        exp_rst.ALUSrcB = 2'b01;

        vt[0]  = '{6'b100011, 6'b000000, 5, {4'd4, 4'd3, 4'd2, 4'd1, 4'd0}};
        vt[1]  = '{6'b101011, 6'b000000, 4, {4'd0, 4'd5, 4'd2, 4'd1, 4'd0}};
        vt[2]  = '{6'b000000, 6'b100000, 4, {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}};
        vt[3]  = '{6'b000000, 6'b001000, 3, {4'd0, 4'd0, 4'd13, 4'd1, 4'd0}};
        vt[4]  = '{6'b000100, 6'b000000, 3, {4'd0, 4'd0, 4'd8, 4'd1, 4'd0}};
        vt[5]  = '{6'b000101, 6'b000000, 3, {4'd0, 4'd0, 4'd8, 4'd1, 4'd0}};
        vt[6]  = '{6'b000010, 6'b000000, 3, {4'd0, 4'd0, 4'd9, 4'd1, 4'd0}};
        vt[7]  = '{6'b000011, 6'b000000, 3, {4'd0, 4'd0, 4'd12, 4'd1, 4'd0}};
        vt[8]  = '{6'b001000, 6'b000000, 4, {4'd0, 4'd11, 4'd10, 4'd1, 4'd0}};
        vt[9]  = '{6'b001100, 6'b000000, 4, {4'd0, 4'd11, 4'd10, 4'd1, 4'd0}};
        vt[10] = '{6'b001101, 6'b000000, 4, {4'd0, 4'd11, 4'd10, 4'd1, 4'd0}};
        vt[11] = '{6'b001010, 6'b000000, 4, {4'd0, 4'd11, 4'd10, 4'd1, 4'd0}};
        vt[12] = '{6'b111111, 6'b000000, 2, {4'd0, 4'd0, 4'd0, 4'd1, 4'd0}};
        vt[13] = '{6'b100000, 6'b001000, 2, {4'd0, 4'd0, 4'd0, 4'd1, 4'd0}};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst0 state", 32'(bus0.state), 32'd0);
        chk("rst0 ctl", 32'(pack0()), 32'(exp_rst));
        @(posedge clk); #1;
        rst0 = 1'b0;

        for (int v = 0; v < 14; v++) begin
            bus0.opcode = vt[v].op;
            bus0.func   = vt[v].fn;
            for (int k = 0; k < int'(vt[v].n); k++) begin
                e.vid = 8'(v);
                e.cyc = 4'(k);
                e.st  = vt[v].path[k];
                e.c   = ref_ctl(e.st, vt[v].op);
                sb_q.push_back(e);
            end
            for (int k = 0; k < int'(vt[v].n); k++) begin
                @(negedge clk);
                e = sb_q.pop_front();
                chk($sformatf("v%0d c%0d state", e.vid, e.cyc), 32'(bus0.state), 32'(e.st));
                chk($sformatf("v%0d c%0d ctl", e.vid, e.cyc), 32'(pack0()), 32'(e.c));
                @(posedge clk); #1;
            end
        end

        // sw on the two-wait instance, memory held off until the fifth MWR cycle.
        rst1 = 1'b0;
        bus1.opcode = 6'b101011;
        @(negedge clk);
        chk("w2 if1 state", 32'(bus1.state), 32'd0);
        chk("w2 if1 MemRd", 32'(bus1.MemRd), 32'd1);
        chk("w2 if1 IRWr", 32'(bus1.IRWr), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("w2 if2 early ready IRWr", 32'(bus1.IRWr), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("w2 if3 IRWr", 32'(bus1.IRWr), 32'd1);
        wait_state1(4'd2, "w2 sw madr");
        bus1.mem_ready = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            if (c == 5) bus1.mem_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("w2 mwr%0d state", c), 32'(bus1.state), 32'd5);
            chk($sformatf("w2 mwr%0d MemWr", c), 32'(bus1.MemWr), 32'(c == 5));
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("w2 after mwr state", 32'(bus1.state), 32'd0);
        chk("w2 after mwr MemWr", 32'(bus1.MemWr), 32'd0);

        // lw with reset landing in the middle of the MRD wait.
        bus1.opcode = 6'b100011;
        wait_state1(4'd2, "w2 lw madr");
        bus1.mem_ready = 1'b0;
        wait_state1(4'd3, "w2 lw mrd");
        chk("w2 mrd lorD", 32'(bus1.lorD), 32'd1);
        chk("w2 mrd MemRd", 32'(bus1.MemRd), 32'd1);
        @(posedge clk); #1;
        rst1 = 1'b1;
        @(negedge clk);
        chk("w2 rst held state", 32'(bus1.state), 32'd3);
        chk("w2 rst masks MemRd", 32'(bus1.MemRd), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("w2 rst state", 32'(bus1.state), 32'd0);
        chk("w2 rst ctl", 32'(pack1()), 32'(exp_rst));
        @(posedge clk); #1;
        rst1 = 1'b0;
        bus1.mem_ready = 1'b1;
        @(negedge clk);
        chk("w2 release state", 32'(bus1.state), 32'd0);
        chk("w2 release MemRd", 32'(bus1.MemRd), 32'd1);
        chk("w2 release IRWr", 32'(bus1.IRWr), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
